rmii_rx_framer: RTL
===================

// Module: rmii_rx_framer
// PURPOSE
// RMII receive front-end: samples crsdv/rxd dibits from the PHY and strips preamble/SFD.
// Assembles payload dibits into bytes and streams them to the MAC receive logic.
// Runs a CRC-32 over the frame and reports a per-frame status.
// Sits directly upstream of the MAC receiver, on the 50 MHz RMII reference clock.
// PARAMETERS
// PRE_MIN  default 8     min consecutive preamble dibits (2'b01) before SFD dibit (2'b11)
// MIN_LEN  default 64    min frame bytes incl. FCS; shorter sets err_len
// MAX_LEN  default 1522  max frame bytes incl. FCS; longer is truncated, sets err_len
// PORTS
// clk      in   1   RMII 50 MHz reference clock; all logic on posedge
// rst_n    in   1   synchronous reset, active-low
// crsdv    in   1   RMII carrier sense / data valid
// rxd      in   2   RMII receive dibit, LSB-first
// data     out  8   received byte (DA..FCS inclusive)
// valid    out  1   one-cycle strobe: data holds a new byte
// sof      out  1   high with valid on the first byte after SFD
// done     out  1   one-cycle strobe at end of frame; status below valid while done=1
// len      out  11  bytes received in the frame, saturates at MAX_LEN
// fcs_ok   out  1   CRC residue correct (valid with done)
// err_align out 1   frame ended on a non-byte boundary (valid with done)
// err_len  out  1   len < MIN_LEN or frame exceeded MAX_LEN (valid with done)
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): state=IDLE; data=0, all strobes and flags=0, len=0; CRC=32'hFFFFFFFF.
// - Reset mid-frame abandons the frame silently: no done pulse.
// - FSM states: IDLE, PREAMBLE, DATA, DROP.
//   IDLE: crsdv=1 -> PREAMBLE with pre_cnt=0.
//     The current dibit is evaluated with the PREAMBLE rules in the same cycle.
//   PREAMBLE:
//     - 2'b01: pre_cnt++, saturating.
//     - 2'b00: pre_cnt=0.
//     - 2'b11 with pre_cnt>=PRE_MIN: -> DATA; clear dibit_cnt, byte count and CRC.
//     - 2'b11 early, or 2'b10: -> DROP.
//     - crsdv=0: -> IDLE, no done.
//   DATA, crsdv=1:
//     - Shift dibit into byte register MSB-ward, so byte = {d3,d2,d1,d0}.
//     - Update CRC per dibit: reflected poly 32'hEDB88320.
//     - dibit_cnt wraps 3->0.
//     - On the 4th dibit, the next cycle gives valid=1, data=byte, and len++.
//     - sof=1 on the first byte only.
//   DATA, crsdv=0: frame ends -> IDLE; done=1 the next cycle.
//   Byte overflow: if a 4th dibit would make len > MAX_LEN, that byte is not emitted.
//     -> DROP with the oversize flag latched.
//   DROP: ignore input; on crsdv=0 -> IDLE.
//     done pulses only if DROP was entered from DATA (oversize).
//     Entry from PREAMBLE produces no done.
// - Status at done:
//   - fcs_ok = (dibit_cnt==0) && (CRC register == 32'hDEBB20E3).
//   - err_align = (dibit_cnt!=0); the partial byte is discarded, not emitted.
//   - err_len = oversize || len<MIN_LEN.
//   - fcs_ok is forced to 0 on oversize.
// - Latency: last dibit of a byte at cycle N -> valid at N+1. Last byte's valid precedes done by >=1 cycle.
// - valid is never asserted in the same cycle as done.
// - Back-to-back frames: a single crsdv=0 cycle between frames is sufficient.
//   IDLE accepts crsdv=1 in the cycle right after done.
// - valid/sof/done are single-cycle pulses and are 0 otherwise. len/flags hold until the next frame's SFD.
// TESTING
// 1. 7x55,D5, then 60 bytes 00..3B plus correct FCS -> 64 valid pulses, data in order.
//    sof on byte 0; done with len=64, fcs_ok=1, err_align=0, err_len=0.
// 2. Same frame with bit 0 of payload byte 10 flipped -> 64 bytes out; done with fcs_ok=0.
// 3. Same frame with crsdv dropped 1 dibit into the last FCS byte -> 63 bytes out.
//    done with err_align=1, fcs_ok=0.
// 4. 1600-byte frame -> exactly 1522 valid pulses; done with len=1522, err_len=1, fcs_ok=0.
//    16-byte frame with valid FCS -> done with len=20, fcs_ok=1, err_len=1.
// 5. Preamble of only 3 dibits of 01 then 11 -> no valid, no done.
//    A following good frame is received correctly.
// 6. rst_n=0 for 1 cycle at byte 30 of frame 1 -> outputs 0, no done.
//    Frame 2 sent after 1 idle cycle -> fcs_ok=1, len=64.

Source files
------------

// File: rtl/rmii_rx_framer.sv
// rmii_rx_framer
// RMII receive front-end. It samples crsdv/rxd dibits on the 50 MHz reference
// clock and strips the preamble and SFD. It packs the payload dibits into bytes
// for the MAC receiver and runs a CRC-32 over the frame. At the end of each
// frame it reports status for that frame.
//
// Ports
//   i_clk        RMII 50 MHz reference clock, all logic on posedge
//   i_rst_n      synchronous reset, active-low
//   i_crsdv      RMII carrier sense / data valid
//   i_rxd[1:0]   RMII receive dibit, LSB-first
//   o_data[7:0]  received byte (DA..FCS inclusive)
//   o_valid      one-cycle strobe, o_data holds a new byte
//   o_sof        high with o_valid on the first byte after SFD
//   o_done       one-cycle end-of-frame strobe, status below valid with it
//   o_len[10:0]  bytes received in the frame, saturates at MAX_LEN
//   o_fcs_ok     CRC residue correct
//   o_err_align  frame ended on a non-byte boundary
//   o_err_len    frame shorter than MIN_LEN or longer than MAX_LEN
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | no carrier; a rising crsdv is judged as a preamble dibit at once
// S_PRE    | counting 01 preamble dibits, waiting for the 11 SFD dibit
// S_DATA   | assembling bytes and running the CRC
// S_DROP   | discarding the rest of the carrier (bad preamble or oversize)
module rmii_rx_framer #(
  parameter int PRE_MIN = 8,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1522
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_crsdv,
  input  logic [1:0]  i_rxd,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_sof,
  output logic        o_done,
  output logic [10:0] o_len,
  output logic        o_fcs_ok,
  output logic        o_err_align,
  output logic        o_err_len
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  localparam int PW = (PRE_MIN < 2) ? 1 : $clog2(PRE_MIN + 1);
  localparam logic [PW-1:0] PRE_SAT     = PW'(PRE_MIN);
  localparam logic [31:0]   CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0]   CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [10:0]   LEN_MAX     = 11'(MAX_LEN);
  localparam logic [10:0]   LEN_MIN     = 11'(MIN_LEN);

  logic [1:0]    r_state;
  logic [PW-1:0] r_pre_cnt;
  logic [1:0]    r_dibit_cnt;
  logic [5:0]    r_shift;
  logic [31:0]   r_crc;
  logic          r_first;
  logic          r_oversize;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_sof;
  logic          r_done;
  logic [10:0]   r_len;
  logic          r_fcs_ok;
  logic          r_err_align;
  logic          r_err_len;

  logic [PW-1:0] w_pre_base;
  logic          w_pre_ok;
  logic [31:0]   w_crc_b0;
  logic [31:0]   w_crc_next;

  // From IDLE the incoming dibit is judged as if the preamble count were zero.
  assign w_pre_base = (r_state == S_IDLE) ? '0 : r_pre_cnt;
  assign w_pre_ok   = (w_pre_base >= PRE_SAT);

  // Reflected CRC-32, two bits per clock, rxd[0] is the earlier bit on the wire.
  assign w_crc_b0   = {1'b0, r_crc[31:1]} ^ ((r_crc[0] ^ i_rxd[0]) ? CRC_POLY : 32'h0);
  assign w_crc_next = {1'b0, w_crc_b0[31:1]} ^ ((w_crc_b0[0] ^ i_rxd[1]) ? CRC_POLY : 32'h0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_pre_cnt   <= '0;
      r_dibit_cnt <= 2'd0;
      r_shift     <= 6'd0;
      r_crc       <= 32'hFFFFFFFF;
      r_first     <= 1'b0;
      r_oversize  <= 1'b0;
      r_data      <= 8'd0;
      r_valid     <= 1'b0;
      r_sof       <= 1'b0;
      r_done      <= 1'b0;
      r_len       <= 11'd0;
      r_fcs_ok    <= 1'b0;
      r_err_align <= 1'b0;
      r_err_len   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE, S_PRE: begin
          if (!i_crsdv) begin
            r_state <= S_IDLE;
          end else begin
            case (i_rxd)
              2'b01: begin
                r_state   <= S_PRE;
                r_pre_cnt <= (w_pre_base < PRE_SAT) ? w_pre_base + PW'(1) : w_pre_base;
              end
              2'b00: begin
                r_state   <= S_PRE;
                r_pre_cnt <= '0;
              end
              2'b11: begin
                if (w_pre_ok) begin
                  // SFD: the previous frame's length and status are released here.
                  r_state     <= S_DATA;
                  r_dibit_cnt <= 2'd0;
                  r_len       <= 11'd0;
                  r_crc       <= 32'hFFFFFFFF;
                  r_first     <= 1'b1;
                  r_oversize  <= 1'b0;
                  r_fcs_ok    <= 1'b0;
                  r_err_align <= 1'b0;
                  r_err_len   <= 1'b0;
                end else begin
                  r_state <= S_DROP;
                end
              end
              default: r_state <= S_DROP;
            endcase
          end
        end
        S_DATA: begin
          if (i_crsdv) begin
            r_crc       <= w_crc_next;
            r_dibit_cnt <= r_dibit_cnt + 2'd1;
            r_shift     <= {i_rxd, r_shift[5:2]};
            if (r_dibit_cnt == 2'd3) begin
              if (r_len >= LEN_MAX) begin
                r_state    <= S_DROP;
                r_oversize <= 1'b1;
              end else begin
                r_valid <= 1'b1;
                r_data  <= {i_rxd, r_shift};
                r_sof   <= r_first;
                r_first <= 1'b0;
                r_len   <= r_len + 11'd1;
              end
            end
          end else begin
            r_state     <= S_IDLE;
            r_done      <= 1'b1;
            r_fcs_ok    <= (r_dibit_cnt == 2'd0) && (r_crc == CRC_RESIDUE);
            r_err_align <= (r_dibit_cnt != 2'd0);
            r_err_len   <= (r_len < LEN_MIN);
          end
        end
        S_DROP: begin
          if (!i_crsdv) begin
            r_state <= S_IDLE;
            // Only an oversize frame (entered from DATA) reports completion.
            if (r_oversize) begin
              r_done      <= 1'b1;
              r_fcs_ok    <= 1'b0;
              r_err_align <= (r_dibit_cnt != 2'd0);
              r_err_len   <= 1'b1;
            end
            r_oversize <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_sof       = r_sof;
  assign o_done      = r_done;
  assign o_len       = r_len;
  assign o_fcs_ok    = r_fcs_ok;
  assign o_err_align = r_err_align;
  assign o_err_len   = r_err_len;

endmodule
